// File: rtl/dec_key_expander_if.sv
// +----------------------------------------------------------------------------+
// | Module      : dec_key_expander_if                                          |
// | Description : Key-load and round-key read bundle for the decryption        |
// |               key expander. master = key source / round logic,             |
// |               slave = expander.                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dec_key_expander_if #(
  parameter int IDX_W = 4
);
  logic [127:0]     key_in;
  logic             key_valid;
  logic             key_ready;
  logic             keys_valid;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_en;
  logic [127:0]     rk_out;
  logic [127:0]     rk_last;

  modport master (
    output key_in, key_valid, rd_idx, rd_en,
    input  key_ready, keys_valid, rk_out, rk_last
  );

  modport slave (
    input  key_in, key_valid, rd_idx, rd_en,
    output key_ready, keys_valid, rk_out, rk_last
  );
endinterface

`default_nettype wire

// File: rtl/dec_key_expander.sv
// +----------------------------------------------------------------------------+
// | Module      : dec_key_expander (+ sbox)                                    |
// | Description : Iterative AES-128 key expansion, one round key per clock,   |
// |               all eleven round keys stored and served by index.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);
  localparam logic [7:0] c_affine = 8'h63;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252;
  logic [7:0] w_inv;

  // Inverse as in^254 through a short addition chain; 0 maps to 0 naturally.
  always_comb begin
    w_x2   = gf_mul(in, in);
    w_x3   = gf_mul(w_x2, in);
    w_x6   = gf_mul(w_x3, w_x3);
    w_x12  = gf_mul(w_x6, w_x6);
    w_x15  = gf_mul(w_x12, w_x3);
    w_x30  = gf_mul(w_x15, w_x15);
    w_x60  = gf_mul(w_x30, w_x30);
    w_x120 = gf_mul(w_x60, w_x60);
    w_x240 = gf_mul(w_x120, w_x120);
    w_x252 = gf_mul(w_x240, w_x12);
    w_inv  = gf_mul(w_x252, w_x2);
    out    = w_inv
           ^ {w_inv[6:0], w_inv[7]}
           ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]}
           ^ {w_inv[3:0], w_inv[7:4]}
           ^ c_affine;
  end
endmodule

module dec_key_expander #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  dec_key_expander_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t           r_state;
  logic [127:0]     r_rk [0:NR];
  logic [127:0]     r_work;
  logic [7:0]       r_rcon;
  logic [IDX_W-1:0] r_cnt;
  logic             r_keys_valid;
  logic             r_key_ready;
  logic [127:0]     r_rk_out;

  logic [31:0]      w_rot;
  logic [31:0]      w_sub;
  logic [31:0]      w_temp;
  logic [31:0]      w_n0, w_n1, w_n2, w_n3;
  logic             w_load;

  // RotWord of the last word of the current round key
  assign w_rot = {r_work[23:0], r_work[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      sbox u_sbox (
        .in  (w_rot[8*gi +: 8]),
        .out (w_sub[8*gi +: 8])
      );
    end
  endgenerate

  // Next round key from the current one
  always_comb begin
    w_temp = w_sub ^ {r_rcon, 24'h000000};
    w_n0   = r_work[127:96] ^ w_temp;
    w_n1   = r_work[95:64]  ^ w_n0;
    w_n2   = r_work[63:32]  ^ w_n1;
    w_n3   = r_work[31:0]   ^ w_n2;
  end

  assign w_load = bus.key_valid & r_key_ready;

  // Control FSM, round-key storage and registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
      r_work       <= '0;
      r_rcon       <= 8'h01;
      r_cnt        <= '0;
      r_keys_valid <= 1'b0;
      r_key_ready  <= 1'b1;
      r_rk_out     <= '0;
    end else begin
      // Read sees the pre-write contents when it hits the index being written
      if (bus.rd_en) begin
        if (bus.rd_idx <= IDX_W'(NR)) r_rk_out <= r_rk[bus.rd_idx];
        else                          r_rk_out <= '0;
      end

      case (r_state)
        IDLE, READY: begin
          if (w_load) begin
            r_rk[0]      <= bus.key_in;
            r_work       <= bus.key_in;
            r_cnt        <= IDX_W'(1);
            r_rcon       <= 8'h01;
            r_keys_valid <= 1'b0;
            r_key_ready  <= 1'b0;
            r_state      <= EXPAND;
          end
        end
        EXPAND: begin
          r_rk[r_cnt] <= {w_n0, w_n1, w_n2, w_n3};
          r_work      <= {w_n0, w_n1, w_n2, w_n3};
          r_rcon      <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
          r_cnt       <= r_cnt + IDX_W'(1);
          if (r_cnt == IDX_W'(NR)) begin
            r_keys_valid <= 1'b1;
            r_key_ready  <= 1'b1;
            r_state      <= READY;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_key_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.key_ready  = r_key_ready;
  assign bus.keys_valid = r_keys_valid;
  assign bus.rk_out     = r_rk_out;
  assign bus.rk_last    = r_rk[NR];
endmodule

`default_nettype wire
